// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: MemWB writeback has priority, long-latency
// results wait in a small FIFO and force a one-cycle stall when starved.
module wb_write_arbiter #(
  parameter int DATA_W   = 32,
  parameter int RD_W     = 8,
  parameter int QDEPTH   = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         wb_data_in,
  input  logic [RD_W-1:0]           wb_rd_in,
  input  logic                      wb_write_in,
  input  logic                      lu_valid_in,
  output logic                      lu_ready_out,
  input  logic [DATA_W-1:0]         lu_data_in,
  input  logic [RD_W-1:0]           lu_rd_in,
  output logic [DATA_W-1:0]         rf_data_out,
  output logic [RD_W-1:0]           rf_rd_out,
  output logic                      rf_write_out,
  output logic                      stall_out,
  output logic [$clog2(QDEPTH):0]   q_count_out
);

  // state | meaning
  // IDLE  | FIFO empty
  // PEND  | FIFO holds results, draining on WB-idle cycles
  // STALL | one cycle: FIFO head takes the port, MemWB held upstream

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);
  localparam logic [CW-1:0] FULL      = CW'(QDEPTH);

  typedef enum logic [1:0] {IDLE, PEND, STALL} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic [DATA_W-1:0] mem_data [QDEPTH];
  logic [RD_W-1:0]   mem_rd   [QDEPTH];
  logic              push, pop, not_empty;

  assign not_empty    = (count_q != '0);
  assign lu_ready_out = reset && (count_q < FULL);
  // rd==0 results finish the handshake but are never stored
  assign push         = lu_valid_in && lu_ready_out && (lu_rd_in != '0);
  assign stall_out    = reset && (state_q == STALL);
  assign q_count_out  = count_q;

  always_comb begin
    rf_write_out = 1'b0;
    rf_data_out  = '0;
    rf_rd_out    = '0;
    pop          = 1'b0;
    if (reset) begin
      if (state_q == STALL) begin
        if (not_empty) begin
          rf_write_out = 1'b1;
          rf_data_out  = mem_data[rd_ptr_q];
          rf_rd_out    = mem_rd[rd_ptr_q];
          pop          = 1'b1;
        end
      end else if (wb_write_in) begin
        rf_write_out = 1'b1;
        rf_data_out  = wb_data_in;
        rf_rd_out    = wb_rd_in;
      end else if (not_empty) begin
        rf_write_out = 1'b1;
        rf_data_out  = mem_data[rd_ptr_q];
        rf_rd_out    = mem_rd[rd_ptr_q];
        pop          = 1'b1;
      end
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    state_d  = state_q;
    wait_d   = wait_q;
    case (state_q)
      IDLE: begin
        wait_d = '0;
        if (push) state_d = PEND;
      end
      PEND: begin
        if (wb_write_in) begin
          if (wait_q == WAIT_LAST) state_d = STALL;
          else                     wait_d  = wait_q + WW'(1);
        end else begin
          wait_d = '0;
          if (count_d == '0) state_d = IDLE;
        end
      end
      STALL: begin
        wait_d  = '0;
        state_d = (count_d != '0) ? PEND : IDLE;
      end
      default: begin
        wait_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wait_q   <= wait_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= lu_data_in;
      mem_rd[wr_ptr_q]   <= lu_rd_in;
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: per-cycle vector table of inputs and
// hand-computed outputs, plus a reset-during-stall sequence.
module tb_wb_write_arbiter;

  logic        clk;
  logic        reset;
  logic [31:0] wb_data_in;
  logic [7:0]  wb_rd_in;
  logic        wb_write_in;
  logic        lu_valid_in;
  logic        lu_ready_out;
  logic [31:0] lu_data_in;
  logic [7:0]  lu_rd_in;
  logic [31:0] rf_data_out;
  logic [7:0]  rf_rd_out;
  logic        rf_write_out;
  logic        stall_out;
  logic [1:0]  q_count_out;

  wb_write_arbiter #(.DATA_W(32), .RD_W(8), .QDEPTH(2), .MAX_WAIT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .wb_data_in   (wb_data_in),
    .wb_rd_in     (wb_rd_in),
    .wb_write_in  (wb_write_in),
    .lu_valid_in  (lu_valid_in),
    .lu_ready_out (lu_ready_out),
    .lu_data_in   (lu_data_in),
    .lu_rd_in     (lu_rd_in),
    .rf_data_out  (rf_data_out),
    .rf_rd_out    (rf_rd_out),
    .rf_write_out (rf_write_out),
    .stall_out    (stall_out),
    .q_count_out  (q_count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_b;
    logic        wb_we;
    logic [7:0]  wb_rd;
    logic [31:0] wb_dat;
    logic        lu_v;
    logic [7:0]  lu_rd;
    logic [31:0] lu_dat;
    logic        e_we;
    logic [7:0]  e_rd;
    logic [31:0] e_dat;
    logic        e_rdy;
    logic        e_stall;
    logic [1:0]  e_cnt;
  } vec_t;

  localparam logic [31:0] WD = 32'h0000_1234;
  localparam logic [7:0]  WR = 8'd5;

  int n_total = 0;
  int n_pass  = 0;
  vec_t vq[$];

  function automatic vec_t mk(logic rst_b, logic wb_we, logic [7:0] wb_rd, logic [31:0] wb_dat,
                              logic lu_v, logic [7:0] lu_rd, logic [31:0] lu_dat,
                              logic e_we, logic [7:0] e_rd, logic [31:0] e_dat,
                              logic e_rdy, logic e_stall, logic [1:0] e_cnt);
    vec_t v;
    v.rst_b = rst_b; v.wb_we = wb_we; v.wb_rd = wb_rd; v.wb_dat = wb_dat;
    v.lu_v = lu_v; v.lu_rd = lu_rd; v.lu_dat = lu_dat;
    v.e_we = e_we; v.e_rd = e_rd; v.e_dat = e_dat;
    v.e_rdy = e_rdy; v.e_stall = e_stall; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s vec=%0d actual=0x%0h required=0x%0h", name, idx, act, exp);
  endtask

  // Called just after a rising edge: drive, check mid-cycle, advance one edge.
  task automatic run_vec(vec_t v, int idx);
    reset       = v.rst_b;
    wb_write_in = v.wb_we;
    wb_rd_in    = v.wb_rd;
    wb_data_in  = v.wb_dat;
    lu_valid_in = v.lu_v;
    lu_rd_in    = v.lu_rd;
    lu_data_in  = v.lu_dat;
    @(negedge clk);
    chk("rf_write", idx, {31'b0, rf_write_out}, {31'b0, v.e_we});
    chk("rf_rd",    idx, {24'b0, rf_rd_out},    {24'b0, v.e_rd});
    chk("rf_data",  idx, rf_data_out,           v.e_dat);
    chk("lu_ready", idx, {31'b0, lu_ready_out}, {31'b0, v.e_rdy});
    chk("stall",    idx, {31'b0, stall_out},    {31'b0, v.e_stall});
    chk("q_count",  idx, {30'b0, q_count_out},  {30'b0, v.e_cnt});
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset hold, then WB-only traffic
    vq.push_back(mk(0,1,WR,WD,    1,8'h03,32'h77,   0,0,0,          0,0,0));
    vq.push_back(mk(1,1,WR,WD,    0,0,0,            1,WR,WD,        1,0,0));
    vq.push_back(mk(1,1,WR,WD,    0,0,0,            1,WR,WD,        1,0,0));
    vq.push_back(mk(1,1,WR,WD,    0,0,0,            1,WR,WD,        1,0,0));
    // LU drain with WB idle
    vq.push_back(mk(1,0,0,0,      1,8'h07,32'hAAAA, 0,0,0,          1,0,0));
    vq.push_back(mk(1,0,0,0,      0,0,0,            1,8'h07,32'hAAAA,1,0,1));
    vq.push_back(mk(1,0,0,0,      0,0,0,            0,0,0,          1,0,0));
    // rd=0 discard
    vq.push_back(mk(1,0,0,0,      1,8'h00,32'h5555, 0,0,0,          1,0,0));
    vq.push_back(mk(1,0,0,0,      0,0,0,            0,0,0,          1,0,0));
    vq.push_back(mk(1,0,0,0,      0,0,0,            0,0,0,          1,0,0));
    // starvation: one entry, WB busy
    vq.push_back(mk(1,1,WR,WD,    1,8'h09,32'hBEEF, 1,WR,WD,        1,0,0));
    vq.push_back(mk(1,1,WR,WD,    0,0,0,            1,WR,WD,        1,0,1));
    vq.push_back(mk(1,1,WR,WD,    0,0,0,            1,WR,WD,        1,0,1));
    vq.push_back(mk(1,1,WR,WD,    0,0,0,            1,WR,WD,        1,0,1));
    vq.push_back(mk(1,1,WR,WD,    0,0,0,            1,WR,WD,        1,0,1));
    vq.push_back(mk(1,1,WR,WD,    0,0,0,            1,8'h09,32'hBEEF,1,1,1));
    vq.push_back(mk(1,1,WR,WD,    0,0,0,            1,WR,WD,        1,0,0));
    vq.push_back(mk(1,0,0,0,      0,0,0,            0,0,0,          1,0,0));
    // full FIFO: three pushes, WB busy
    vq.push_back(mk(1,1,WR,WD,    1,8'h11,32'h1111, 1,WR,WD,        1,0,0));
    vq.push_back(mk(1,1,WR,WD,    1,8'h12,32'h2222, 1,WR,WD,        1,0,1));
    vq.push_back(mk(1,1,WR,WD,    1,8'h13,32'h3333, 1,WR,WD,        0,0,2));
    vq.push_back(mk(1,1,WR,WD,    1,8'h13,32'h3333, 1,WR,WD,        0,0,2));
    vq.push_back(mk(1,1,WR,WD,    1,8'h13,32'h3333, 1,WR,WD,        0,0,2));
    vq.push_back(mk(1,1,WR,WD,    1,8'h13,32'h3333, 1,8'h11,32'h1111,0,1,2));
    vq.push_back(mk(1,1,WR,WD,    1,8'h13,32'h3333, 1,WR,WD,        1,0,1));
    vq.push_back(mk(1,1,WR,WD,    0,0,0,            1,WR,WD,        0,0,2));
    vq.push_back(mk(1,0,0,0,      0,0,0,            1,8'h12,32'h2222,0,0,2));
    vq.push_back(mk(1,0,0,0,      0,0,0,            1,8'h13,32'h3333,1,0,1));
    vq.push_back(mk(1,0,0,0,      0,0,0,            0,0,0,          1,0,0));

    reset = 1'b0; wb_write_in = 1'b0; wb_rd_in = '0; wb_data_in = '0;
    lu_valid_in = 1'b0; lu_rd_in = '0; lu_data_in = '0;
    repeat (2) @(posedge clk);
    #1;

    foreach (vq[i]) run_vec(vq[i], i);

    // Reset while in STALL with two entries buffered
    run_vec(mk(1,1,WR,WD, 1,8'h21,32'hA1, 1,WR,WD, 1,0,0), 100);
    run_vec(mk(1,1,WR,WD, 1,8'h22,32'hA2, 1,WR,WD, 1,0,1), 101);
    run_vec(mk(1,1,WR,WD, 0,0,0,          1,WR,WD, 0,0,2), 102);
    run_vec(mk(1,1,WR,WD, 0,0,0,          1,WR,WD, 0,0,2), 103);
    run_vec(mk(1,1,WR,WD, 0,0,0,          1,WR,WD, 0,0,2), 104);
    run_vec(mk(0,1,WR,WD, 1,8'h23,32'hA3, 0,0,0,   0,0,2), 105);
    run_vec(mk(1,0,0,0,   0,0,0,          0,0,0,   1,0,0), 106);
    run_vec(mk(1,0,0,0,   0,0,0,          0,0,0,   1,0,0), 107);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
